// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-ported unified memory between instruction fetch
// and the load/store port. Data wins ties unless fetch has been passed over
// STARVE_MAX times in a row; accesses that never see mem_ready_i are aborted.
module rv_mem_arb #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_ack_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            d_rd_i,
    input  logic            d_wr_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_wstrb_i,
    output logic            d_ack_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_wstrb_o,
    input  logic            mem_ready_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            if_ack_q, if_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            d_ack_q, d_ack_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            if_elig;
    logic            d_elig;
    logic            grant_if;
    logic            grant_d;
    logic            timed_out;

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Arbitration, transaction tracking and next-output computation.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        err_d       = 1'b0;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        timed_out   = 1'b0;

        // A requester being acked this cycle is dropping its request.
        if_elig = if_req_i && !if_ack_q;
        d_elig  = (d_rd_i || d_wr_i) && !d_ack_q;

        case (state_q)
            IDLE: begin
                grant_if = if_elig && (!d_elig || (starve_q == CW'(STARVE_MAX)));
                grant_d  = d_elig && !grant_if;

                if (!if_req_i || grant_if) begin
                    starve_d = '0;
                end else if (grant_d && (starve_q != CW'(STARVE_MAX))) begin
                    starve_d = starve_q + CW'(1);
                end

                if (grant_if) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    tmo_d       = '0;
                end else if (grant_d) begin
                    // Simultaneous read and write decode is handled as a store.
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_wstrb_d = d_wr_i ? d_wstrb_i : '0;
                    tmo_d       = '0;
                end
            end

            BUSY_IF, BUSY_D: begin
                timed_out = (TIMEOUT != 0) && !mem_ready_i &&
                            (tmo_q == TW'(TIMEOUT - 1));
                if (mem_ready_i || timed_out) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    err_d       = timed_out;
                    if (state_q == BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = timed_out ? '0 : mem_rdata_i;
                    end else begin
                        d_ack_d = 1'b1;
                        if (timed_out) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Testbench for rv_mem_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_rv_mem_arb;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_ack_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_rd_i;
    logic          d_wr_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [SW-1:0] d_wstrb_i;
    logic          d_ack_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_wstrb_o;
    logic          mem_ready_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;
    logic          err_o;

    always #5 clk = ~clk;

    rv_mem_arb #(
        .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
        .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct packed {
        logic          if_ack;
        logic [DW-1:0] if_rdata;
        logic          d_ack;
        logic [DW-1:0] d_rdata;
        logic          mem_req;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic [SW-1:0] mem_wstrb;
        logic          busy;
        logic          err;
    } out_t;

    typedef struct {
        logic          ifr;
        logic [AW-1:0] ifa;
        logic          drd;
        logic          dwr;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        logic          rdy;
        logic [DW-1:0] rd;
        out_t          exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // model / random driver state
    out_t e;
    int   m_owner;   // 0 none, 1 fetch, 2 data
    int   m_wait;
    int   m_starve;
    bit   if_pend;
    bit   d_pend;
    int   d_kind;
    int   stall_left;

    function automatic out_t o(input logic ia, input logic [DW-1:0] ird,
                               input logic da, input logic [DW-1:0] drd,
                               input logic mr, input logic mw,
                               input logic [AW-1:0] ma, input logic [DW-1:0] wd,
                               input logic [SW-1:0] ws, input logic b,
                               input logic er);
        out_t r;
        r.if_ack = ia;  r.if_rdata = ird; r.d_ack = da; r.d_rdata = drd;
        r.mem_req = mr; r.mem_we = mw; r.mem_addr = ma; r.mem_wdata = wd;
        r.mem_wstrb = ws; r.busy = b; r.err = er;
        return r;
    endfunction

    function automatic vec_t mkv(input logic ifr, input logic [AW-1:0] ifa,
                                 input logic drd, input logic dwr,
                                 input logic [AW-1:0] da, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] ws, input logic rdy,
                                 input logic [DW-1:0] rd, input out_t exp);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.drd = drd; v.dwr = dwr; v.da = da;
        v.wd = wd; v.ws = ws; v.rdy = rdy; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    function automatic out_t dut_out();
        out_t r;
        r.if_ack = if_ack_o;   r.if_rdata = if_rdata_o;
        r.d_ack = d_ack_o;     r.d_rdata = d_rdata_o;
        r.mem_req = mem_req_o; r.mem_we = mem_we_o; r.mem_addr = mem_addr_o;
        r.mem_wdata = mem_wdata_o; r.mem_wstrb = mem_wstrb_o;
        r.busy = busy_o;       r.err = err_o;
        return r;
    endfunction

    // Write data only matters while a store is on the bus.
    task automatic check(input string name, input out_t exp);
        out_t act;
        act = dut_out();
        if (!exp.mem_we) begin
            act.mem_wdata = '0;
            exp.mem_wdata = '0;
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        if_req_i = v.ifr; if_addr_i = v.ifa; d_rd_i = v.drd; d_wr_i = v.dwr;
        d_addr_i = v.da; d_wdata_i = v.wd; d_wstrb_i = v.ws;
        mem_ready_i = v.rdy; mem_rdata_i = v.rd;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; if_addr_i = '0; d_rd_i = 1'b0; d_wr_i = 1'b0;
        d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
    endtask

    // Random requesters obey the hold-until-ack protocol; withdrawals only before grant.
    task automatic drive_random();
        if (e.if_ack) if_pend = 1'b0;
        if (e.d_ack)  d_pend  = 1'b0;
        if (if_pend && m_owner != 1 && $urandom_range(0, 31) == 0) if_pend = 1'b0;
        if (d_pend  && m_owner != 2 && $urandom_range(0, 31) == 0) d_pend  = 1'b0;
        if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend   = 1'b1;
            if_addr_i = $urandom;
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend    = 1'b1;
            d_kind    = int'($urandom_range(0, 3));
            d_addr_i  = $urandom;
            d_wdata_i = $urandom;
            d_wstrb_i = SW'($urandom);
        end
        if_req_i = if_pend;
        d_rd_i   = d_pend && (d_kind != 2);
        d_wr_i   = d_pend && (d_kind >= 2);
        if (stall_left > 0) begin
            stall_left--;
            mem_ready_i = 1'b0;
        end else begin
            if ($urandom_range(0, 47) == 0) stall_left = 12;
            mem_ready_i = ($urandom_range(0, 2) != 0);
        end
        mem_rdata_i = $urandom;
    endtask

    // Predict outputs after the next edge from the inputs now applied.
    task automatic model_step();
        out_t n;
        bit   ie, de, fin, to;
        int   g;
        n = e;
        n.if_ack = 1'b0; n.d_ack = 1'b0; n.err = 1'b0;
        if (m_owner == 0) begin
            ie = if_req_i && !e.if_ack;
            de = (d_rd_i || d_wr_i) && !e.d_ack;
            g  = 0;
            if (ie && de)  g = (m_starve == int'(SMAX)) ? 1 : 2;
            else if (ie)   g = 1;
            else if (de)   g = 2;
            if (!if_req_i || g == 1) m_starve = 0;
            else if (g == 2 && m_starve < int'(SMAX)) m_starve = m_starve + 1;
            if (g == 1) begin
                n.mem_req = 1'b1; n.mem_we = 1'b0; n.mem_addr = if_addr_i;
                n.mem_wstrb = '0;
            end else if (g == 2) begin
                n.mem_req = 1'b1; n.mem_we = d_wr_i; n.mem_addr = d_addr_i;
                n.mem_wdata = d_wdata_i; n.mem_wstrb = d_wr_i ? d_wstrb_i : '0;
            end
            if (g != 0) begin
                m_owner = g;
                m_wait  = 0;
            end
        end else begin
            fin = 1'b0; to = 1'b0;
            if (mem_ready_i) begin
                fin = 1'b1;
            end else begin
                m_wait = m_wait + 1;
                if (TMO != 0 && m_wait == int'(TMO)) begin
                    fin = 1'b1; to = 1'b1;
                end
            end
            if (fin) begin
                n.mem_req = 1'b0; n.mem_we = 1'b0; n.mem_wstrb = '0; n.err = to;
                if (m_owner == 1) begin
                    n.if_ack = 1'b1;
                    n.if_rdata = to ? '0 : mem_rdata_i;
                end else begin
                    n.d_ack = 1'b1;
                    if (to)             n.d_rdata = '0;
                    else if (!e.mem_we) n.d_rdata = mem_rdata_i;
                end
                m_owner = 0;
            end
        end
        n.busy = (m_owner != 0);
        e = n;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vec[9];
        int   nb;
        bit   seen;
        bit   expect_d;
        int   acks;
        logic [DW-1:0] rd_drv;

        // fetch alone, exclusion during ack, then fetch+store collision
        vec[0] = mkv(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hCAFE0001,
                     o(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h100, '0, '0, 1'b1, 1'b0));
        vec[1] = mkv(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hCAFE0001,
                     o(1'b1, 32'hCAFE0001, 1'b0, '0, 1'b0, 1'b0, 32'h100, '0, '0, 1'b0, 1'b0));
        vec[2] = mkv(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hCAFE0001,
                     o(1'b0, 32'hCAFE0001, 1'b0, '0, 1'b0, 1'b0, 32'h100, '0, '0, 1'b0, 1'b0));
        vec[3] = mkv(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0BADF00D,
                     o(1'b0, 32'hCAFE0001, 1'b0, '0, 1'b0, 1'b0, 32'h100, '0, '0, 1'b0, 1'b0));
        vec[4] = mkv(1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1, 32'h11111111,
                     o(1'b0, 32'hCAFE0001, 1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0));
        vec[5] = mkv(1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1, 32'h11111111,
                     o(1'b0, 32'hCAFE0001, 1'b1, '0, 1'b0, 1'b0, 32'h200, '0, '0, 1'b0, 1'b0));
        vec[6] = mkv(1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1, 32'h11111111,
                     o(1'b0, 32'hCAFE0001, 1'b0, '0, 1'b1, 1'b0, 32'h300, '0, '0, 1'b1, 1'b0));
        vec[7] = mkv(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h22222222,
                     o(1'b1, 32'h22222222, 1'b0, '0, 1'b0, 1'b0, 32'h300, '0, '0, 1'b0, 1'b0));
        vec[8] = mkv(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                     o(1'b0, 32'h22222222, 1'b0, '0, 1'b0, 1'b0, 32'h300, '0, '0, 1'b0, 1'b0));

        idle_inputs();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", '0);
        rstn = 1'b1;
        step();
        check("post_reset_idle", '0);

        for (int k = 0; k < 9; k++) begin
            apply(vec[k]);
            step();
            check($sformatf("vec%0d", k), vec[k].exp);
        end

        // load with three wait states
        d_rd_i = 1'b1; d_addr_i = 32'h80; mem_ready_i = 1'b0;
        step();
        check("ld_grant", o(1'b0, 32'h22222222, 1'b0, '0, 1'b1, 1'b0, 32'h80, '0, '0, 1'b1, 1'b0));
        for (int w = 0; w < 3; w++) begin
            step();
            check($sformatf("ld_wait%0d", w),
                  o(1'b0, 32'h22222222, 1'b0, '0, 1'b1, 1'b0, 32'h80, '0, '0, 1'b1, 1'b0));
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h12345678;
        step();
        check("ld_ack", o(1'b0, 32'h22222222, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h80, '0, '0, 1'b0, 1'b0));
        d_rd_i = 1'b0; mem_ready_i = 1'b0; mem_rdata_i = '0;
        step();
        check("ld_done", o(1'b0, 32'h22222222, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h80, '0, '0, 1'b0, 1'b0));

        // timeout with ready held low
        d_rd_i = 1'b1; d_addr_i = 32'h44; mem_ready_i = 1'b0; mem_rdata_i = 32'hFFFFFFFF;
        step();
        check("tmo_grant", o(1'b0, 32'h22222222, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h44, '0, '0, 1'b1, 1'b0));
        nb   = busy_o ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (d_ack_o) seen = 1'b1;
            else if (busy_o) nb++;
        end
        check_val("tmo_ack_seen", 64'(seen), 64'(1));
        check_val("tmo_busy_cycles", 64'(nb), 64'(TMO));
        check("tmo_exit", o(1'b0, 32'h22222222, 1'b1, '0, 1'b0, 1'b0, 32'h44, '0, '0, 1'b0, 1'b1));
        d_rd_i = 1'b0;
        step();
        check("tmo_after", o(1'b0, 32'h22222222, 1'b0, '0, 1'b0, 1'b0, 32'h44, '0, '0, 1'b0, 1'b0));
        if_req_i = 1'b1; if_addr_i = 32'h500; mem_ready_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
        step();
        check("post_tmo_grant", o(1'b0, 32'h22222222, 1'b0, '0, 1'b1, 1'b0, 32'h500, '0, '0, 1'b1, 1'b0));
        step();
        check("post_tmo_ack", o(1'b1, 32'h55AA55AA, 1'b0, '0, 1'b0, 1'b0, 32'h500, '0, '0, 1'b0, 1'b0));
        idle_inputs();
        step();

        // both requesters held continuously: ownership must alternate, data first
        if_req_i = 1'b1; if_addr_i = 32'h600; d_rd_i = 1'b1; d_addr_i = 32'h700;
        mem_ready_i = 1'b1;
        expect_d = 1'b1;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            mem_rdata_i = 32'hA5A50000 | 32'(i);
            rd_drv = mem_rdata_i;
            step();
            if (if_ack_o || d_ack_o) begin
                acks++;
                check_val("alt_owner", 64'({if_ack_o, d_ack_o}), expect_d ? 64'd1 : 64'd2);
                check_val("alt_rdata", 64'(expect_d ? d_rdata_o : if_rdata_o), 64'(rd_drv));
                expect_d = !expect_d;
            end
        end
        check_val("alt_acks", 64'(acks), 64'd8);
        idle_inputs();
        step();
        check_val("alt_idle", 64'(busy_o), 64'd0);

        // asynchronous reset in the middle of a store
        d_wr_i = 1'b1; d_addr_i = 32'h900; d_wdata_i = 32'h1; d_wstrb_i = 4'h3; mem_ready_i = 1'b0;
        step();
        check_val("rst_pre_req", 64'({mem_req_o, mem_we_o, busy_o}), 64'd7);
        #2 rstn = 1'b0;
        #1 check("rst_mid_busy", '0);
        @(negedge clk);
        mem_ready_i = 1'b1; d_wr_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_after%0d", i), '0);
        end

        // randomized traffic against the model
        e = '0; m_owner = 0; m_wait = 0; m_starve = 0;
        if_pend = 1'b0; d_pend = 1'b0; d_kind = 0; stall_left = 0;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            model_step();
            step();
            check("rand", e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
